fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_next_pc.sv | 23 ++
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  localparam int unsigned IwDefault = 10;
  localparam int unsigned DwDefault = 9;
  localparam logic [8:0] HaltCodeDefault = 9'b111111111;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: hold, absolute/relative branch, or increment (wrapping).
module fetch_next_pc #(
  parameter int unsigned IW = 10
) (
  input  logic [IW-1:0] pc,
  input  logic          hold,
  input  logic          branch,
  input  logic          branch_abs,
  input  logic [IW-1:0] target,
  output logic [IW-1:0] next_pc
);

  // Sums are truncated to IW bits, giving modulo-2^IW wrap for free.
  always_comb begin
    next_pc = pc + IW'(1);
    if (hold) begin
      next_pc = pc;
    end else if (branch) begin
      next_pc = branch_abs ? target : pc + target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: IDLE/RUN/HALT sequencer driving a combinational instruction ROM.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned   IW        = IwDefault,
  parameter int unsigned   DW        = DwDefault,
  parameter logic [DW-1:0] HALT_CODE = DW'(HaltCodeDefault)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          BranchTaken,
  input  logic          BranchAbs,
  input  logic [IW-1:0] Target,
  input  logic [DW-1:0] InstIn,
  output logic [IW-1:0] InstAddress,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
  output logic [15:0]   CycleCount
);

  state_e        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [IW-1:0] next_pc;
  logic          is_halt;
  logic          start_ok;

  assign is_halt  = (InstIn == HALT_CODE);
  assign start_ok = Start && (state_q != StRun);

  // A halt word also holds the PC so it parks on the halt address.
  fetch_next_pc #(
    .IW(IW)
  ) u_next_pc (
    .pc        (pc_q),
    .hold      (Stall | is_halt),
    .branch    (BranchTaken),
    .branch_abs(BranchAbs),
    .target    (Target),
    .next_pc   (next_pc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StRun;
      StRun:   if (!Stall && is_halt) state_d = StHalt;
      StHalt:  if (Start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    InstValid = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state_q)
      StRun: begin
        InstValid = 1'b1;
        Busy      = 1'b1;
      end
      StHalt:  Done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (start_ok) begin
      pc_d  = StartAddr;
      cnt_d = '0;
    end else if (state_q == StRun) begin
      pc_d = next_pc;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl with a queue of expected post-edge outputs.
module tb_fetch_ctrl;

  localparam int unsigned IW = 10;
  localparam int unsigned DW = 9;
  localparam logic [DW-1:0] NH = 9'h000;
  localparam logic [DW-1:0] HC = 9'h1FF;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic [IW-1:0] StartAddr = '0;
  logic          Stall = 1'b0;
  logic          BranchTaken = 1'b0;
  logic          BranchAbs = 1'b0;
  logic [IW-1:0] Target = '0;
  logic [DW-1:0] InstIn = '0;
  logic [IW-1:0] InstAddress;
  logic          InstValid;
  logic          Busy;
  logic          Done;
  logic [15:0]   CycleCount;

  always #5 Clk = ~Clk;

  fetch_ctrl #(
    .IW       (IW),
    .DW       (DW),
    .HALT_CODE(HC)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Stall      (Stall),
    .BranchTaken(BranchTaken),
    .BranchAbs  (BranchAbs),
    .Target     (Target),
    .InstIn     (InstIn),
    .InstAddress(InstAddress),
    .InstValid  (InstValid),
    .Busy       (Busy),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  typedef struct packed {
    logic [IW-1:0] addr;
    logic          valid;
    logic          busy;
    logic          done;
    logic [15:0]   cnt;
  } exp_t;

  typedef struct packed {
    logic          start;
    logic [IW-1:0] saddr;
    logic          stall;
    logic          br;
    logic          abs;
    logic [IW-1:0] tgt;
    logic [DW-1:0] inst;
    exp_t          exp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [IW-1:0] a, input logic v, input logic b,
                              input logic d, input logic [15:0] c);
    exp_t e;
    e.addr = a; e.valid = v; e.busy = b; e.done = d; e.cnt = c;
    return e;
  endfunction

  function automatic vec_t mv(input logic st, input logic [IW-1:0] sa, input logic sl,
                              input logic br, input logic ab, input logic [IW-1:0] tg,
                              input logic [DW-1:0] in, input exp_t e);
    vec_t x;
    x.start = st; x.saddr = sa; x.stall = sl; x.br = br; x.abs = ab; x.tgt = tg;
    x.inst = in; x.exp = e;
    return x;
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t got;
    got = mk(InstAddress, InstValid, Busy, Done, CycleCount);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got addr=%h valid=%b busy=%b done=%b cnt=%0d, want addr=%h valid=%b busy=%b done=%b cnt=%0d",
               name, got.addr, got.valid, got.busy, got.done, got.cnt,
               e.addr, e.valid, e.busy, e.done, e.cnt);
    end
  endtask

  task automatic drive(input vec_t v);
    Start = v.start; StartAddr = v.saddr; Stall = v.stall;
    BranchTaken = v.br; BranchAbs = v.abs; Target = v.tgt; InstIn = v.inst;
  endtask

  initial begin
    // Idle, start, sequential run to halt at 5
    vecs[0]  = mv(0, 10'h000, 1, 1, 1, 10'h155, NH, mk(10'h000, 0, 0, 0, 0));
    vecs[1]  = mv(1, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h000, 1, 1, 0, 0));
    vecs[2]  = mv(0, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h001, 1, 1, 0, 1));
    vecs[3]  = mv(0, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h002, 1, 1, 0, 2));
    vecs[4]  = mv(0, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h003, 1, 1, 0, 3));
    vecs[5]  = mv(0, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h004, 1, 1, 0, 4));
    vecs[6]  = mv(0, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h005, 1, 1, 0, 5));
    vecs[7]  = mv(0, 10'h000, 0, 0, 0, 10'h000, HC, mk(10'h005, 0, 0, 1, 6));
    vecs[8]  = mv(0, 10'h000, 1, 1, 1, 10'h123, HC, mk(10'h005, 0, 0, 1, 6));
    // Restart at 10, relative then absolute branch, Start ignored while running
    vecs[9]  = mv(1, 10'h00A, 0, 0, 0, 10'h000, HC, mk(10'h00A, 1, 1, 0, 0));
    vecs[10] = mv(0, 10'h000, 0, 1, 0, 10'h3FD, NH, mk(10'h007, 1, 1, 0, 1));
    vecs[11] = mv(0, 10'h000, 0, 1, 1, 10'h200, NH, mk(10'h200, 1, 1, 0, 2));
    vecs[12] = mv(1, 10'h3FF, 0, 0, 0, 10'h000, NH, mk(10'h201, 1, 1, 0, 3));
    vecs[13] = mv(0, 10'h000, 0, 1, 1, 10'h011, HC, mk(10'h201, 0, 0, 1, 4));
    // Wrap from 3FF, then stall over a halt word at 4
    vecs[14] = mv(1, 10'h3FF, 0, 0, 0, 10'h000, HC, mk(10'h3FF, 1, 1, 0, 0));
    vecs[15] = mv(0, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h000, 1, 1, 0, 1));
    vecs[16] = mv(0, 10'h000, 0, 1, 1, 10'h004, NH, mk(10'h004, 1, 1, 0, 2));
    vecs[17] = mv(0, 10'h000, 1, 0, 0, 10'h000, HC, mk(10'h004, 1, 1, 0, 3));
    vecs[18] = mv(0, 10'h000, 1, 0, 0, 10'h000, HC, mk(10'h004, 1, 1, 0, 4));
    vecs[19] = mv(0, 10'h000, 1, 1, 1, 10'h100, HC, mk(10'h004, 1, 1, 0, 5));
    vecs[20] = mv(0, 10'h000, 0, 1, 1, 10'h100, HC, mk(10'h004, 0, 0, 1, 6));
    vecs[21] = mv(1, 10'h040, 0, 0, 0, 10'h000, HC, mk(10'h040, 1, 1, 0, 0));
    vecs[22] = mv(0, 10'h000, 0, 0, 0, 10'h000, NH, mk(10'h041, 1, 1, 0, 1));

    // Reset state, with inputs wiggling and clock edges passing
    Start = 1'b1; Stall = 1'b1; BranchTaken = 1'b1; StartAddr = 10'h2AA;
    repeat (2) @(posedge Clk);
    #1 check("reset_state", mk('0, 0, 0, 0, 0));
    drive(mv(0, 0, 0, 0, 0, 0, NH, mk(0, 0, 0, 0, 0)));
    Reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i].exp);
      @(posedge Clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty at vec%0d: got size 0, want >0", i);
      end else begin
        check($sformatf("vec%0d", i), sb.pop_front());
      end
    end

    // Asynchronous reset mid-RUN, away from any clock edge
    #2 Reset_n = 1'b0;
    #1 check("async_reset", mk('0, 0, 0, 0, 0));
    @(posedge Clk);
    #1 check("reset_held", mk('0, 0, 0, 0, 0));
    Reset_n = 1'b1;
    @(posedge Clk);
    #1 check("idle_after_reset", mk('0, 0, 0, 0, 0));

    drive(mv(1, 10'h123, 0, 0, 0, 0, NH, mk(0, 0, 0, 0, 0)));
    sb.push_back(mk(10'h123, 1, 1, 0, 0));
    @(posedge Clk);
    #1 check("start_after_reset", sb.pop_front());
    drive(mv(0, 0, 0, 0, 0, 0, NH, mk(0, 0, 0, 0, 0)));
    sb.push_back(mk(10'h124, 1, 1, 0, 1));
    @(posedge Clk);
    #1 check("run_after_reset", sb.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
